// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a framed byte stream into instruction-memory writes.
// The core is kept in reset until a complete, checksum-verified image has been written.
module imem_loader #(
    parameter int NUM_WORDS = 32,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int          IDX_W   = $clog2(NUM_WORDS + 1);
    localparam logic [15:0] MAX_LEN = 16'(NUM_WORDS);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR} state_t;

    state_t           state;
    state_t           next_state;
    logic [15:0]      len;
    logic [15:0]      full_len;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_cnt;
    logic [7:0]       acc;
    logic [23:0]      word_lo;
    logic             accept;
    logic             restart;
    logic             last_word;
    logic             in_ready_d;
    logic             busy_d;
    logic             done_d;
    logic             error_d;
    logic             core_reset_d;
    logic             mem_we_d;

    assign accept    = in_valid && in_ready;
    assign restart   = start && (state == IDLE || state == DONE || state == ERROR);
    assign full_len  = {in_data, len[7:0]};
    assign last_word = ((16'(word_idx) + 16'd1) == len);

    // State and registered outputs; status flags are decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            core_reset <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= next_state;
            in_ready   <= in_ready_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            core_reset <= core_reset_d;
            mem_we     <= mem_we_d;
            if (mem_we_d) begin
                mem_addr  <= ADDR_W'({word_idx, 2'b00});
                mem_wdata <= {in_data, word_lo};
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: if (start) next_state = LEN0;
            LEN0:              if (accept) next_state = LEN1;
            LEN1: begin
                if (accept)
                    next_state = (full_len == 16'd0 || full_len > MAX_LEN) ? ERROR : DATA;
            end
            DATA:              if (accept && byte_cnt == 2'd3 && last_word) next_state = CSUM;
            CSUM:              if (accept) next_state = (in_data == acc) ? DONE : ERROR;
            default:           next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        core_reset_d = 1'b1;
        case (next_state)
            LEN0, LEN1, DATA, CSUM: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            DONE: begin
                done_d       = 1'b1;
                core_reset_d = 1'b0;
            end
            ERROR:   error_d = 1'b1;
            default: ;
        endcase
        mem_we_d = accept && (state == DATA) && (byte_cnt == 2'd3);
    end

    // Header latch, little-endian word assembly and running XOR of data bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len      <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            acc      <= '0;
            word_lo  <= '0;
        end else if (restart) begin
            word_idx <= '0;
            byte_cnt <= '0;
            acc      <= '0;
        end else if (accept) begin
            case (state)
                LEN0: len[7:0]  <= in_data;
                LEN1: len[15:8] <= in_data;
                DATA: begin
                    acc      <= acc ^ in_data;
                    byte_cnt <= byte_cnt + 2'd1;
                    case (byte_cnt)
                        2'd0:    word_lo[7:0]   <= in_data;
                        2'd1:    word_lo[15:8]  <= in_data;
                        2'd2:    word_lo[23:16] <= in_data;
                        default: word_idx       <= word_idx + IDX_W'(1);
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// tb_imem_loader: directed frames checked every cycle against a frame-level model of the loader.
module tb_imem_loader;
    localparam int NUM_WORDS = 32;

    typedef enum int {PH_IDLE, PH_BUSY, PH_DONE, PH_ERR} phase_t;
    typedef struct { int stamp; logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int stamp; phase_t phase; } ph_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    wr_t         exp_wr[$];
    wr_t         act_wr[$];
    wr_t         cur_exp;
    ph_t         ph_q[$];
    phase_t      cur_phase = PH_IDLE;

    logic [7:0]  frame[$];
    logic [31:0] mdl_data[$];
    bit          mdl_len_err;
    bit          mdl_csum_ok;
    int          mdl_len;

    imem_loader #(.NUM_WORDS(NUM_WORDS), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_reset(core_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_phase(input phase_t p);
        ph_q.push_back('{cyc + 1, p});
    endtask

    // Frame-level reference: decode the header, build words little-endian, XOR the data bytes.
    task automatic model_frame();
        logic [7:0] x;
        x = 8'h00;
        mdl_data.delete();
        mdl_csum_ok = 1'b0;
        mdl_len = int'(frame[0]) + 256 * int'(frame[1]);
        mdl_len_err = (mdl_len == 0 || mdl_len > NUM_WORDS);
        if (!mdl_len_err) begin
            for (int w = 0; w < mdl_len; w++) begin
                mdl_data.push_back({frame[2+4*w+3], frame[2+4*w+2], frame[2+4*w+1], frame[2+4*w]});
                for (int k = 0; k < 4; k++) x ^= frame[2+4*w+k];
            end
            mdl_csum_ok = (frame[2+4*mdl_len] == x);
        end
    endtask

    task automatic applyStimulus(input bit gapped, input bit inject, input int stop_after);
        int g;
        model_frame();
        @(negedge clk);
        start = 1'b1;
        push_phase(PH_BUSY);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < frame.size(); j++) begin
            if (stop_after >= 0 && j >= stop_after) break;
            if (gapped) begin
                g = $urandom_range(0, 2);
                repeat (g) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = frame[j];
            start    = inject && (j == 4);
            if (j == 1 && mdl_len_err) push_phase(PH_ERR);
            if (!mdl_len_err && j >= 2 && j < 2 + 4*mdl_len && (j - 2) % 4 == 3)
                exp_wr.push_back('{cyc + 1, 32'(((j - 2) / 4) * 4), mdl_data[(j - 2) / 4]});
            if (!mdl_len_err && j == 2 + 4*mdl_len)
                push_phase(mdl_csum_ok ? PH_DONE : PH_ERR);
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
            in_data  = 8'hA5;
            if (j == 1 && mdl_len_err) break;
        end
    endtask

    // Per-cycle compare of status outputs and write strobes against the model's schedule.
    always @(negedge clk) begin
        if (!reset) begin
            while (ph_q.size() > 0 && ph_q[0].stamp <= cyc) cur_phase = ph_q.pop_front().phase;
            checkOutput("in_ready", in_ready, cur_phase == PH_BUSY);
            checkOutput("busy", busy, cur_phase == PH_BUSY);
            checkOutput("done", done, cur_phase == PH_DONE);
            checkOutput("error", error, cur_phase == PH_ERR);
            checkOutput("core_reset", core_reset, cur_phase != PH_DONE);
            if (mem_we) begin
                act_wr.push_back('{cyc, mem_addr, mem_wdata});
                if (exp_wr.size() == 0 || exp_wr[0].stamp != cyc) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr %h data %h expected no write (cycle %0d)",
                             mem_addr, mem_wdata, cyc);
                end else begin
                    cur_exp = exp_wr.pop_front();
                    checkOutput("mem_addr", mem_addr, cur_exp.addr);
                    checkOutput("mem_wdata", mem_wdata, cur_exp.data);
                end
            end else if (exp_wr.size() > 0 && exp_wr[0].stamp <= cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL missing_write: got mem_we 0 expected write addr %h (cycle %0d)",
                         exp_wr[0].addr, cyc);
                void'(exp_wr.pop_front());
            end
        end
    end

    task automatic check_two_words(input string tag);
        checkOutput({tag, "_nwrites"}, act_wr.size(), 2);
        if (act_wr.size() >= 2) begin
            checkOutput({tag, "_addr0"}, act_wr[0].addr, 32'h0000_0000);
            checkOutput({tag, "_data0"}, act_wr[0].data, 32'h0000_0013);
            checkOutput({tag, "_addr1"}, act_wr[1].addr, 32'h0000_0004);
            checkOutput({tag, "_data1"}, act_wr[1].data, 32'h0200_006F);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_core_reset", core_reset, 1);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] good two-word frame");
        frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h02, 8'h7E};
        act_wr.delete();
        applyStimulus(1'b0, 1'b0, -1);
        checkOutput("good_done", done, 1);
        checkOutput("good_core_reset", core_reset, 0);
        repeat (3) @(negedge clk);
        check_two_words("good");

        $display("[TB] bad checksum then good frame");
        frame[10] = 8'h7F;
        act_wr.delete();
        applyStimulus(1'b0, 1'b0, -1);
        repeat (3) @(negedge clk);
        check_two_words("badcs");
        checkOutput("badcs_error", error, 1);
        checkOutput("badcs_core_reset", core_reset, 1);
        frame[10] = 8'h7E;
        applyStimulus(1'b0, 1'b0, -1);
        repeat (3) @(negedge clk);
        checkOutput("recover_done", done, 1);

        $display("[TB] header errors");
        frame = '{8'h21, 8'h00};
        act_wr.delete();
        applyStimulus(1'b0, 1'b0, -1);
        checkOutput("len33_error", error, 1);
        repeat (3) @(negedge clk);
        frame = '{8'h00, 8'h00};
        applyStimulus(1'b0, 1'b0, -1);
        checkOutput("len0_error", error, 1);
        repeat (3) @(negedge clk);
        checkOutput("hdr_nwrites", act_wr.size(), 0);

        $display("[TB] gapped stream with stray start");
        frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h02, 8'h7E};
        act_wr.delete();
        applyStimulus(1'b1, 1'b1, -1);
        repeat (3) @(negedge clk);
        check_two_words("gap");
        checkOutput("gap_done", done, 1);

        $display("[TB] reset mid-frame");
        act_wr.delete();
        applyStimulus(1'b0, 1'b0, 4);
        reset = 1'b1;
        #1;
        checkOutput("midrst_in_ready", in_ready, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_core_reset", core_reset, 1);
        checkOutput("midrst_mem_we", mem_we, 0);
        exp_wr.delete();
        ph_q.delete();
        cur_phase = PH_IDLE;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midrst_nwrites", act_wr.size(), 0);
        applyStimulus(1'b0, 1'b0, -1);
        repeat (3) @(negedge clk);
        check_two_words("restart");

        checkOutput("pending_writes", exp_wr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory read by the single-cycle RISC-V core. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written to consecutive byte addresses 0, 4, 8, …, matching the core's PC-indexed fetch. The loader holds the core in reset until a checksum-verified image has been fully written.

## Interface

Parameters:
- NUM_WORDS, 32, maximum image length in words; a larger header length is an error.
- ADDR_W, 32, width of mem_addr (byte address).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR; ignored in all other states.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid & in_ready.
- mem_we  output  1  one-cycle instruction-memory write strobe.
- mem_addr  output  ADDR_W  byte address of the write, word_idx*4.
- mem_wdata  output  32  assembled instruction word.
- core_reset  output  1  holds the core in reset; low only in DONE.
- busy  output  1  high in LEN0, LEN1, DATA, CSUM.
- done  output  1  image loaded and verified.
- error  output  1  length or checksum failure.

## Operation

- Frame format: len[7:0], len[15:8], then 4*len data bytes (little-endian per word), then 1 checksum byte. The checksum is the XOR of all data bytes; header bytes are excluded.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
- IDLE: in_ready=0, core_reset=1. A start pulse moves to LEN0 and clears word_idx, byte_cnt, the XOR accumulator, done and error.
- LEN0: accepting a byte latches len[7:0] and moves to LEN1.
- LEN1: accepting a byte latches len[15:8].
  - If the full 16-bit len is 0 or greater than NUM_WORDS, move to ERROR.
  - Otherwise move to DATA.
- DATA:
  - The accepted byte k (byte_cnt = 0..3) goes to word[8k+7:8k] and is XORed into the accumulator.
  - When byte k=3 is accepted, the next cycle has mem_we=1, mem_addr=word_idx*4, and mem_wdata = the assembled word. word_idx then increments and byte_cnt wraps to 0.
  - After byte 3 of word len-1 is accepted, move to CSUM.
- CSUM: accepting the checksum byte moves to DONE if it equals the accumulator, otherwise to ERROR.
- DONE: done=1, core_reset=0, in_ready=0. A start pulse re-enters LEN0 and reasserts core_reset.
- ERROR: error=1, core_reset=1, in_ready=0. A start pulse re-enters LEN0.
- in_ready=1 in LEN0, LEN1, DATA and CSUM regardless of mem_we, so back-to-back bytes at one per cycle are supported.
- mem_we is only ever produced from DATA; no write occurs on a length or checksum error. Words already written before a checksum failure remain in memory.
- A start pulse in LEN0, LEN1, DATA or CSUM is ignored. Bytes presented while in_ready=0 are not consumed.
- word_idx is ceil(log2(NUM_WORDS+1)) bits wide; mem_addr = {word_idx, 2'b00}, zero-extended.

## Timing

- Reset values:
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, busy=0, done=0, error=0.
  - Internal counters and the accumulator are 0.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously). A pending write strobe is cancelled. A new start is required.
- All outputs are registered.
- start → busy=1 and in_ready=1 on the next cycle.
- Write latency: mem_we is high exactly one cycle, in the cycle after the 4th byte of a word is accepted.
- Checksum byte accepted in cycle t → done=1 and core_reset=0 in cycle t+1 (or error=1).
- The last data write and the checksum acceptance may coincide in the same cycle; both must take effect.
- Minimum frame time: 2 + 4*len + 1 accepted-byte cycles plus 1 cycle to DONE.

## Test plan

- Reset, no stimulus → in_ready=0, mem_we=0, core_reset=1, done=0, error=0 for 10 cycles.
- start, then bytes 02 00 | 13 00 00 00 | 6F 00 00 02 | 7E at one per cycle → exactly two writes: (0x0, 0x00000013) and (0x4, 0x0200006F). Then done=1 and core_reset=0 one cycle after the 7E byte.
- Same frame with checksum 7F → both words written, error=1, done=0, core_reset stays 1. A second start with a correct frame then reaches DONE.
- Header 21 00 (33 > NUM_WORDS=32) → error=1 after the second byte, no mem_we. Header 00 00 → same response.
- The frame from scenario 2 with randomly gapped in_valid, plus a start pulse injected during DATA → identical writes and done; the start is ignored.
- Reset asserted after 2 data bytes → immediate reset values, no write. Restart with a full frame → correct writes from address 0.
